p2m_demux: RTL and testbench

Parametrised pipe-to-method demultiplexer with multi-beat message reassembly. It accepts tagged words from a `PipeIn` server port and reassembles messages spanning up to `MAX_BEATS` beats into one MSB-aligned payload. Each completed message is presented, registered, to one of `NUM_METHODS` method channels. Malformed and unroutable messages are counted rather than forwarded. It replaces the fixed, single-beat, combinational per-interface demarshallers between the host pipe and the request-method consumers.

---
 rtl/p2m_pkg.sv | 24 ++
 rtl/p2m_demux_if.sv | 28 ++
 rtl/p2m_sat_counter.sv | 14 +
 rtl/p2m_demux.sv | 133 +++++++++++++
 tb/tb_p2m_demux.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/p2m_pkg.sv
// Shared types and header helpers for the pipe-to-method demultiplexer.
// The header is the top TAG_W bits of a beat word: LAST flag on top, method id below it.
package p2m_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ASSEMBLE, S_DISCARD, S_DISPATCH} p2m_state_t;

  // LAST is the header MSB; the id fills everything under it down to bit 0
  localparam int P2M_LAST_FROM_TOP = 1;
  localparam int P2M_ID_LSB        = 0;

  // Headers are passed zero-extended to 32 bits, so TAG_W is limited to 32
  function automatic logic [31:0] p2m_hdr_id(input logic [31:0] hdr, input int tag_w);
    logic [31:0] mask;
    mask = (32'd1 << (tag_w - P2M_LAST_FROM_TOP)) - 32'd1;
    return (hdr >> P2M_ID_LSB) & mask;
  endfunction

  function automatic logic p2m_hdr_last(input logic [31:0] hdr, input int tag_w);
    logic [31:0] s;
    s = hdr >> (tag_w - P2M_LAST_FROM_TOP);
    return s[0];
  endfunction

endpackage

// File: rtl/p2m_demux_if.sv
// Beat intake (pipe side) and method dispatch (consumer side) bundle.
interface p2m_demux_if #(
  parameter int NUM_METHODS = 4,
  parameter int TAG_W       = 16,
  parameter int BEAT_W      = 128,
  parameter int MAX_BEATS   = 4
);
  localparam int MSG_W = BEAT_W * MAX_BEATS;
  localparam int LEN_W = $clog2(MAX_BEATS + 1);

  logic                    pipe_enq__ENA;
  logic [TAG_W+BEAT_W-1:0] pipe_enq_v;
  logic                    pipe_enq__RDY;
  logic [NUM_METHODS-1:0]  method__ENA;
  logic [NUM_METHODS-1:0]  method__RDY;
  logic [MSG_W-1:0]        method_v;
  logic [LEN_W-1:0]        method_len;

  modport master (
    output pipe_enq__ENA, pipe_enq_v, method__RDY,
    input  pipe_enq__RDY, method__ENA, method_v, method_len
  );

  modport slave (
    input  pipe_enq__ENA, pipe_enq_v, method__RDY,
    output pipe_enq__RDY, method__ENA, method_v, method_len
  );
endinterface

// File: rtl/p2m_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module p2m_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge CLK) begin
    if (nRST)                   count <= '0;
    else if (inc && count != '1) count <= count + WIDTH'(1);
  end
endmodule

// File: rtl/p2m_demux.sv
// Reassembles tagged multi-beat messages from the pipe and dispatches each one,
// MSB-aligned and registered, to its method channel; bad messages only bump counters.
module p2m_demux
  import p2m_pkg::*;
#(
  parameter int NUM_METHODS = 4,
  parameter int TAG_W       = 16,
  parameter int BEAT_W      = 128,
  parameter int MAX_BEATS   = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  p2m_demux_if.slave  bus,
  output logic [15:0] err_bad_id,
  output logic [15:0] err_proto
);
  localparam int MSG_W = BEAT_W * MAX_BEATS;
  localparam int LEN_W = $clog2(MAX_BEATS + 1);
  localparam int ID_W  = TAG_W - 1;

  p2m_state_t             state_q, state_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic [MSG_W-1:0]       pay_q, pay_d;
  logic                   pend_bad_q, pend_bad_d;
  logic [NUM_METHODS-1:0] ena_q, ena_d;
  logic                   rdy_q;
  logic                   bad_inc, proto_inc;

  logic [31:0]       hdr, id_full;
  logic [ID_W-1:0]   beat_id;
  logic              last, id_ok, acc;
  logic [BEAT_W-1:0] beat;

  assign hdr     = 32'(bus.pipe_enq_v[TAG_W+BEAT_W-1 -: TAG_W]);
  assign beat    = bus.pipe_enq_v[BEAT_W-1:0];
  assign id_full = p2m_hdr_id(hdr, TAG_W);
  assign beat_id = ID_W'(id_full);
  assign last    = p2m_hdr_last(hdr, TAG_W);
  assign id_ok   = id_full < 32'(NUM_METHODS);
  assign acc     = bus.pipe_enq__ENA && rdy_q;

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    pay_d      = pay_q;
    pend_bad_d = pend_bad_q;
    bad_inc    = 1'b0;
    proto_inc  = 1'b0;
    ena_d      = '0;
    case (state_q)
      S_IDLE: if (acc) begin
        if (!id_ok) begin
          if (last) bad_inc = 1'b1;
          else begin
            state_d    = S_DISCARD;
            pend_bad_d = 1'b1;
          end
        end else begin
          id_d                       = beat_id;
          pay_d                      = '0;
          pay_d[MSG_W-1 -: BEAT_W]   = beat;
          cnt_d                      = LEN_W'(1);
          state_d                    = last ? S_DISPATCH : S_ASSEMBLE;
        end
      end
      S_ASSEMBLE: if (acc) begin
        // A foreign id or a beat past MAX_BEATS poisons the rest of the message
        if (beat_id != id_q || cnt_q == LEN_W'(MAX_BEATS)) begin
          if (last) begin
            proto_inc = 1'b1;
            state_d   = S_IDLE;
          end else begin
            state_d    = S_DISCARD;
            pend_bad_d = 1'b0;
          end
        end else begin
          for (int k = 1; k < MAX_BEATS; k++)
            if (cnt_q == LEN_W'(k)) pay_d[MSG_W-1-k*BEAT_W -: BEAT_W] = beat;
          cnt_d = cnt_q + LEN_W'(1);
          if (last) state_d = S_DISPATCH;
        end
      end
      S_DISCARD: if (acc && last) begin
        bad_inc   = pend_bad_q;
        proto_inc = !pend_bad_q;
        state_d   = S_IDLE;
      end
      S_DISPATCH: if ((ena_q & bus.method__RDY) != '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) begin
      pay_d = '0;
      cnt_d = '0;
    end
    for (int m = 0; m < NUM_METHODS; m++)
      ena_d[m] = (state_d == S_DISPATCH) && (id_d == ID_W'(m));
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q    <= S_IDLE;
      id_q       <= '0;
      cnt_q      <= '0;
      pay_q      <= '0;
      pend_bad_q <= 1'b0;
      ena_q      <= '0;
      rdy_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      pay_q      <= pay_d;
      pend_bad_q <= pend_bad_d;
      ena_q      <= ena_d;
      rdy_q      <= (state_d != S_DISPATCH);
    end
  end

  assign bus.pipe_enq__RDY = rdy_q;
  assign bus.method__ENA   = ena_q;
  assign bus.method_v      = pay_q;
  assign bus.method_len    = cnt_q;

  p2m_sat_counter #(.WIDTH(16)) u_cnt_bad (
    .CLK(CLK), .nRST(nRST), .inc(bad_inc), .count(err_bad_id)
  );

  p2m_sat_counter #(.WIDTH(16)) u_cnt_proto (
    .CLK(CLK), .nRST(nRST), .inc(proto_inc), .count(err_proto)
  );
endmodule

// File: tb/tb_p2m_demux.sv
// Scenario bench for p2m_demux: dispatches are scoreboarded, counters and
// handshake timing are checked inline per scenario.
module tb_p2m_demux;
  localparam int NM = 4, TW = 16, BW = 128, MB = 4;
  localparam int MSGW = BW * MB;
  localparam int LENW = $clog2(MB + 1);

  typedef struct {
    logic [NM-1:0]   ena;
    logic [MSGW-1:0] v;
    logic [LENW-1:0] len;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic [15:0] err_bad_id, err_proto;
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0;
  int          exp_bad = 0, exp_proto = 0;
  exp_t        q[$];

  p2m_demux_if #(.NUM_METHODS(NM), .TAG_W(TW), .BEAT_W(BW), .MAX_BEATS(MB)) bus ();

  p2m_demux #(.NUM_METHODS(NM), .TAG_W(TW), .BEAT_W(BW), .MAX_BEATS(MB)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus), .err_bad_id(err_bad_id), .err_proto(err_proto)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Scoreboard: every handshake must match the oldest expected message
  always @(negedge CLK) begin
    if (!nRST && (bus.method__ENA & bus.method__RDY) != '0) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL dispatch_unexpected ena=%b", bus.method__ENA);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.method__ENA !== e.ena || bus.method_v !== e.v || bus.method_len !== e.len) begin
          n_err++;
          $display("FAIL dispatch ena=%b/%b len=%0d/%0d v=%h exp=%h",
                   bus.method__ENA, e.ena, bus.method_len, e.len, bus.method_v, e.v);
        end
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_beat(input logic [14:0] id, input logic last, input logic [127:0] d);
    int w = 0;
    bus.pipe_enq__ENA = 1'b1;
    bus.pipe_enq_v    = {last, id, d};
    while (!bus.pipe_enq__RDY && w < 50) begin
      @(posedge CLK); #1; w++;
    end
    if (w >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout id=%0d rdy=%b", id, bus.pipe_enq__RDY);
    end else begin
      @(posedge CLK); #1;
    end
    bus.pipe_enq__ENA = 1'b0;
  endtask

  // Sends an L-beat message for a valid id and queues its expected dispatch
  task automatic send_msg(input int id, input int len);
    exp_t         e;
    logic [127:0] d;
    e.v   = '0;
    e.ena = NM'(1) << id;
    e.len = LENW'(len);
    for (int k = 0; k < len; k++) begin
      d = rnd128();
      e.v[MSGW-1-k*BW -: BW] = d;
      if (k == len - 1) q.push_back(e);
      send_beat(15'(id), k == len - 1, d);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b0;
    @(posedge CLK); #1;
    n_cmp++;
    if (bus.pipe_enq__RDY !== 1'b1 || bus.method__ENA !== '0 || bus.method_v !== '0 ||
        bus.method_len !== '0 || err_bad_id !== 16'd0 || err_proto !== 16'd0) begin
      n_err++;
      $display("FAIL reset rdy=%b ena=%b len=%0d bad=%0d proto=%0d (want 1 0 0 0 0)",
               bus.pipe_enq__RDY, bus.method__ENA, bus.method_len, err_bad_id, err_proto);
    end
  endtask

  task automatic test_single_beat();
    exp_t         e;
    logic [127:0] d;
    bus.method__RDY = 4'hF;
    d = {32'hDEADBEEF, 96'(rnd128())};
    e.ena = 4'b0010; e.len = 1; e.v = {d, 384'b0};
    q.push_back(e);
    send_beat(15'd1, 1'b1, d);
    n_cmp++;
    if (bus.method__ENA !== 4'b0010 || bus.method_v[511:480] !== 32'hDEADBEEF ||
        bus.method_v[383:0] !== '0 || bus.method_len !== 1) begin
      n_err++;
      $display("FAIL single_dispatch ena=%b top=%h len=%0d (want 0010 deadbeef 1)",
               bus.method__ENA, bus.method_v[511:480], bus.method_len);
    end
    @(posedge CLK); #1;
    n_cmp++;
    if (bus.method__ENA !== 4'b0 || bus.pipe_enq__RDY !== 1'b1) begin
      n_err++;
      $display("FAIL single_release ena=%b rdy=%b (want 0000 1)", bus.method__ENA, bus.pipe_enq__RDY);
    end
  endtask

  task automatic test_blocked();
    exp_t         e;
    logic [127:0] a, b, c;
    a = rnd128(); b = rnd128(); c = rnd128();
    bus.method__RDY = 4'b1011;
    e.ena = 4'b0100; e.len = 3; e.v = {a, b, c, 128'h0};
    q.push_back(e);
    send_beat(15'd2, 1'b0, a);
    send_beat(15'd2, 1'b0, b);
    send_beat(15'd2, 1'b1, c);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.method__ENA !== 4'b0100 || bus.method_v !== e.v || bus.method_len !== 3 ||
          bus.pipe_enq__RDY !== 1'b0) begin
        n_err++;
        $display("FAIL blocked_hold cyc%0d ena=%b len=%0d rdy=%b", i, bus.method__ENA,
                 bus.method_len, bus.pipe_enq__RDY);
      end
      if (i < 4) begin @(posedge CLK); #1; end
    end
    bus.method__RDY = 4'hF;
    @(posedge CLK); #1;
    n_cmp++;
    if (bus.method__ENA !== 4'b0 || bus.pipe_enq__RDY !== 1'b1) begin
      n_err++;
      $display("FAIL blocked_release ena=%b rdy=%b", bus.method__ENA, bus.pipe_enq__RDY);
    end
  endtask

  task automatic test_bad_id();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (bus.pipe_enq__RDY !== 1'b1) begin
        n_err++;
        $display("FAIL bad_id_rdy beat%0d rdy=%b", k, bus.pipe_enq__RDY);
      end
      send_beat(15'd7, k == 1, rnd128());
    end
    exp_bad++;
    n_cmp++;
    if (err_bad_id !== 16'(exp_bad) || bus.method__ENA !== '0 || bus.pipe_enq__RDY !== 1'b1) begin
      n_err++;
      $display("FAIL bad_id cnt=%0d want=%0d ena=%b rdy=%b", err_bad_id, exp_bad,
               bus.method__ENA, bus.pipe_enq__RDY);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 5; k++) send_beat(15'd0, k == 4, rnd128());
    exp_proto++;
    n_cmp++;
    if (err_proto !== 16'(exp_proto) || bus.method__ENA !== '0) begin
      n_err++;
      $display("FAIL overflow proto=%0d want=%0d ena=%b", err_proto, exp_proto, bus.method__ENA);
    end
    send_msg(0, 1);
    n_cmp++;
    if (bus.method__ENA !== 4'b0001 || bus.method_v[383:0] !== '0) begin
      n_err++;
      $display("FAIL overflow_next ena=%b low_nonzero=%b", bus.method__ENA, |bus.method_v[383:0]);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_id_change();
    send_beat(15'd3, 1'b0, rnd128());
    send_beat(15'd1, 1'b1, rnd128());
    exp_proto++;
    n_cmp++;
    if (err_proto !== 16'(exp_proto) || err_bad_id !== 16'(exp_bad) || bus.method__ENA !== '0) begin
      n_err++;
      $display("FAIL id_change proto=%0d want=%0d bad=%0d want=%0d ena=%b",
               err_proto, exp_proto, err_bad_id, exp_bad, bus.method__ENA);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    bus.method__RDY = 4'hF;
    c0 = cyc;
    for (int m = 0; m < 3; m++) send_msg(m, 2);
    @(posedge CLK); #1;
    n_cmp++;
    if (cyc - c0 !== 9 || bus.pipe_enq__RDY !== 1'b1 || q.size() != 0) begin
      n_err++;
      $display("FAIL back_to_back cycles=%0d want=9 rdy=%b pending=%0d", cyc - c0,
               bus.pipe_enq__RDY, q.size());
    end
    for (int m = 0; m < 6; m++) send_msg(int'($urandom_range(0, NM - 1)), int'($urandom_range(1, MB)));
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid();
    send_beat(15'd0, 1'b0, rnd128());
    send_beat(15'd0, 1'b0, rnd128());
    nRST = 1'b1;
    @(posedge CLK); #1;
    nRST = 1'b0;
    exp_bad = 0; exp_proto = 0;
    n_cmp++;
    if (bus.pipe_enq__RDY !== 1'b1 || bus.method__ENA !== '0 || bus.method_len !== '0 ||
        bus.method_v !== '0 || err_bad_id !== 16'd0 || err_proto !== 16'd0) begin
      n_err++;
      $display("FAIL reset_mid rdy=%b ena=%b len=%0d bad=%0d proto=%0d",
               bus.pipe_enq__RDY, bus.method__ENA, bus.method_len, err_bad_id, err_proto);
    end
    send_msg(0, 1);
    n_cmp++;
    if (bus.method_len !== 1 || bus.method__ENA !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_mid_fresh len=%0d ena=%b (want 1 0001)", bus.method_len, bus.method__ENA);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_saturation();
    bus.pipe_enq__ENA = 1'b1;
    bus.pipe_enq_v    = {1'b1, 15'd7, 128'h0};
    repeat (65535) @(posedge CLK);
    #1 bus.pipe_enq__ENA = 1'b0;
    n_cmp++;
    if (err_bad_id !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_preload cnt=%h want=ffff", err_bad_id);
    end
    send_beat(15'd7, 1'b1, 128'h0);
    n_cmp++;
    if (err_bad_id !== 16'hFFFF || err_proto !== 16'd0) begin
      n_err++;
      $display("FAIL sat_hold bad=%h want=ffff proto=%0d want=0", err_bad_id, err_proto);
    end
  endtask

  initial begin
    bus.pipe_enq__ENA = 1'b0;
    bus.pipe_enq_v    = '0;
    bus.method__RDY   = 4'hF;
    test_reset();
    test_single_beat();
    test_blocked();
    test_bad_id();
    test_overflow();
    test_id_change();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain pending=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
